// File: rtl/pixel_fb_pkg.sv
// Shared types for the pixel framebuffer writer: FSM states and the 96-bit
// pixel record layout popped from the GL core's pixel FIFO.
package pixel_fb_pkg;

    localparam int REC_W   = 96;
    localparam int COORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_CLIP,
        ST_ZRD,
        ST_ZWR,
        ST_WR
    } state_t;

    // Packed so that x lands in [95:80], y in [79:64], z in [63:32], RGBA in [31:0].
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [31:0]        z;
        logic [31:0]        color;
    } pixel_rec_t;

endpackage

// File: rtl/pixel_fb_writer_fb_addr_gen.sv
// Linear pixel offset generator: off = y*SCREEN_W + x, registered when i_en.
// The offset is held until the next enabled cycle so later states can reuse it.
module fb_addr_gen
    import pixel_fb_pkg::*;
#(
    parameter int unsigned SCREEN_W = 640
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_en,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [31:0]        o_off
);

    logic [31:0] r_off;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_off <= '0;
        end else if (i_en) begin
            r_off <= 32'(i_y) * 32'(SCREEN_W) + 32'(i_x);
        end
    end

    assign o_off = r_off;

endmodule

// File: rtl/pixel_fb_writer.sv
// Pops pixel records, clips them to the screen and writes colour via req/ack.
// Define DEPTH_TEST_EN to add the depth-buffer read-compare-write before the colour write.
module pixel_fb_writer
    import pixel_fb_pkg::*;
#(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter logic [31:0] FB_BASE  = 32'h0000_0000,
    parameter logic [31:0] Z_BASE   = 32'h0004_B000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REC_W-1:0] pixel_fifo_dout,
    input  logic             pixel_fifo_empty,
    output logic             pixel_fifo_rd_en,
    output logic             fb_req,
    output logic [31:0]      fb_addr,
    output logic [31:0]      fb_wdata,
    input  logic             fb_ack,
    output logic             z_req,
    output logic             z_we,
    output logic [31:0]      z_addr,
    output logic [31:0]      z_wdata,
    input  logic [31:0]      z_rdata,
    input  logic             z_ack,
    output logic             busy,
    output logic [15:0]      pix_written,
    output logic [15:0]      pix_dropped
);

    state_t             r_state;
    logic               r_run;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [31:0]        r_z;
    logic [31:0]        r_color;
    logic               r_fb_req;
    logic [31:0]        r_fb_addr;
    logic [31:0]        r_fb_wdata;
    logic [15:0]        r_written;
    logic [15:0]        r_dropped;

    pixel_rec_t         w_rec;
    logic [31:0]        w_off;
    logic               w_clipped;

    assign w_rec     = pixel_fifo_dout;
    assign w_clipped = ({16'd0, r_x} >= SCREEN_W) || ({16'd0, r_y} >= SCREEN_H);

    // r_run keeps the pop strobe quiet while reset is held and for the first cycle after.
    assign pixel_fifo_rd_en = r_run && (r_state == ST_IDLE) && !pixel_fifo_empty;
    assign busy             = (r_state != ST_IDLE);

    // Fed straight from the FIFO output during POP so the offset is ready in CLIP.
    fb_addr_gen #(
        .SCREEN_W (SCREEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (r_state == ST_POP),
        .i_x     (w_rec.x),
        .i_y     (w_rec.y),
        .o_off   (w_off)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

`ifdef DEPTH_TEST_EN
    logic        r_z_req;
    logic        r_z_we;
    logic [31:0] r_z_addr;
    logic [31:0] r_z_wdata;

    assign z_req   = r_z_req;
    assign z_we    = r_z_we;
    assign z_addr  = r_z_addr;
    assign z_wdata = r_z_wdata;
`else
    logic w_unused;

    assign z_req    = 1'b0;
    assign z_we     = 1'b0;
    assign z_addr   = 32'd0;
    assign z_wdata  = 32'd0;
    assign w_unused = ^{r_z, z_rdata, z_ack, Z_BASE};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_color    <= '0;
            r_fb_req   <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_wdata <= '0;
            r_written  <= '0;
            r_dropped  <= '0;
`ifdef DEPTH_TEST_EN
            r_z_req    <= 1'b0;
            r_z_we     <= 1'b0;
            r_z_addr   <= '0;
            r_z_wdata  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pixel_fifo_rd_en) begin
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    r_x     <= w_rec.x;
                    r_y     <= w_rec.y;
                    r_z     <= w_rec.z;
                    r_color <= w_rec.color;
                    r_state <= ST_CLIP;
                end
                ST_CLIP: begin
                    if (w_clipped) begin
                        r_dropped <= r_dropped + 16'd1;
                        r_state   <= ST_IDLE;
                    end else begin
`ifdef DEPTH_TEST_EN
                        r_z_req  <= 1'b1;
                        r_z_we   <= 1'b0;
                        r_z_addr <= Z_BASE + w_off;
                        r_state  <= ST_ZRD;
`else
                        r_fb_req   <= 1'b1;
                        r_fb_addr  <= FB_BASE + w_off;
                        r_fb_wdata <= r_color;
                        r_state    <= ST_WR;
`endif
                    end
                end
`ifdef DEPTH_TEST_EN
                ST_ZRD: begin
                    if (z_ack) begin
                        // Strictly-less passes; an equal depth is treated as hidden.
                        if (r_z < z_rdata) begin
                            r_z_we    <= 1'b1;
                            r_z_wdata <= r_z;
                            r_state   <= ST_ZWR;
                        end else begin
                            r_z_req   <= 1'b0;
                            r_dropped <= r_dropped + 16'd1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_ZWR: begin
                    if (z_ack) begin
                        r_z_req    <= 1'b0;
                        r_z_we     <= 1'b0;
                        r_fb_req   <= 1'b1;
                        r_fb_addr  <= FB_BASE + w_off;
                        r_fb_wdata <= r_color;
                        r_state    <= ST_WR;
                    end
                end
`endif
                ST_WR: begin
                    if (fb_ack) begin
                        r_fb_req  <= 1'b0;
                        r_written <= r_written + 16'd1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fb_req      = r_fb_req;
    assign fb_addr     = r_fb_addr;
    assign fb_wdata    = r_fb_wdata;
    assign pix_written = r_written;
    assign pix_dropped = r_dropped;

endmodule
